// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer handlers.
// Pointer conversion helpers work on a 32-bit container; callers
// truncate the result to their own pointer width.
package afifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary over the low 'width' bits: bit i is the XOR of bits width-1 down to i.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        bin = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (i == width - 1)
                bin[i] = gray[i];
            else
                bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterised combinational Gray-to-binary converter, shared by both
// pointer handlers for turning a synchronised Gray pointer into binary.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the reduction XOR of the Gray bits at and above it.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign bin[gi] = ^gray[W-1:gi];
    end

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer and status controller of the asynchronous FIFO.
// Keeps binary/Gray write pointers and derives registered full,
// almost-full, fill level and a sticky overflow flag against the read
// pointer already synchronised into the write clock domain.
module wptr_handler
    import afifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int AF_THRESH = 6
) (
    input  logic               wclk,
    input  logic               rst_n,
    input  logic               w_en,
    input  logic [PTR_WIDTH:0] g_rptr_sync,
    input  logic               overflow_clr,
    output logic               w_fire,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wlevel,
    output logic               overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_LEVEL = PW'(AF_THRESH);

    logic [PTR_WIDTH:0] b_wptr_reg, b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_reg, g_wptr_next;
    logic [PTR_WIDTH:0] wlevel_reg, wlevel_next;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] g_rptr_full;
    logic               full_reg, full_next;
    logic               almost_full_reg, almost_full_next;
    logic               overflow_reg;

    gray2bin #(
        .W(PW)
    ) u_rptr_g2b (
        .gray(g_rptr_sync),
        .bin (b_rptr_sync)
    );

    // Writes are accepted only while not full; a dropped write leaves the pointers alone.
    assign w_fire = w_en & ~full_reg;

    // Next pointers and status derived from the pointer after this cycle's write.
    always_comb begin
        b_wptr_next      = b_wptr_reg + PW'(w_fire);
        g_wptr_next      = PW'(bin2gray(32'(b_wptr_next)));
        // Full when write is exactly one lap ahead: Gray form differs in the two MSBs only.
        g_rptr_full      = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
        full_next        = (g_wptr_next == g_rptr_full);
        wlevel_next      = b_wptr_next - b_rptr_sync;
        almost_full_next = (wlevel_next >= AF_LEVEL);
    end

    // Pointer and status registers.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            b_wptr_reg      <= '0;
            g_wptr_reg      <= '0;
            wlevel_reg      <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
        end else begin
            b_wptr_reg      <= b_wptr_next;
            g_wptr_reg      <= g_wptr_next;
            wlevel_reg      <= wlevel_next;
            full_reg        <= full_next;
            almost_full_reg <= almost_full_next;
        end
    end

    // Sticky overflow: a write attempt while full wins over a same-cycle clear.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)
            overflow_reg <= 1'b0;
        else if (w_en && full_reg)
            overflow_reg <= 1'b1;
        else if (overflow_clr)
            overflow_reg <= 1'b0;
    end

    assign b_wptr      = b_wptr_reg;
    assign g_wptr      = g_wptr_reg;
    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign wlevel      = wlevel_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_wptr_handler.sv
// Self-checking bench for wptr_handler (PTR_WIDTH=3, AF_THRESH=6).
// A counting model (write count, read count, level) predicts every output;
// directed scenarios add literal expectations, then random traffic runs.
module tb_wptr_handler;

    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic       wclk;
    logic       rst_n;
    logic       w_en;
    logic       overflow_clr;
    logic [3:0] rd_ptr;
    logic [3:0] g_rptr_sync;
    logic       w_fire;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: pointers as integers modulo 16.
    int m_w, m_lvl;
    bit m_full, m_af, m_ov;

    assign g_rptr_sync = rd_ptr ^ (rd_ptr >> 1);

    wptr_handler #(
        .PTR_WIDTH(PW),
        .AF_THRESH(AF)
    ) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .g_rptr_sync (g_rptr_sync),
        .overflow_clr(overflow_clr),
        .w_fire      (w_fire),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: level is simply writes minus reads, full means a whole lap.
    always @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            m_w = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ov = 0;
        end else begin
            if (w_en && m_full) m_ov = 1;
            else if (overflow_clr) m_ov = 0;
            if (w_en && !m_full) m_w = (m_w + 1) % 16;
            m_lvl  = (m_w - int'(rd_ptr) + 16) % 16;
            if (m_lvl == 0 && m_w != int'(rd_ptr)) m_lvl = 16;
            m_lvl  = (m_w - int'(rd_ptr) + 32) % 16;
            if (m_lvl > DEPTH) m_lvl = m_lvl; // unreachable for legal read pointers
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= AF);
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge wclk) begin
        int g;
        g = m_w ^ (m_w >> 1);
        chk("w_fire",      32'(w_fire),      32'(w_en && !m_full));
        chk("b_wptr",      32'(b_wptr),      32'(m_w));
        chk("g_wptr",      32'(g_wptr),      32'(g));
        chk("full",        32'(full),        32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("wlevel",      32'(wlevel),      32'(m_lvl));
        chk("overflow",    32'(overflow),    32'(m_ov));
    end

    // One cycle: apply inputs, let one rising edge pass, return 2 time units later.
    task automatic tick(input bit we, input int rd, input bit clr);
        w_en         = we;
        rd_ptr       = 4'(rd);
        overflow_clr = clr;
        @(posedge wclk);
        #2;
        $display("cyc we=%0b rd=%0d clr=%0b -> b=%0d g=%b lvl=%0d full=%0b af=%0b ov=%0b",
                 we, rd, clr, b_wptr, g_wptr, wlevel, full, almost_full, overflow);
    endtask

    initial begin
        bit saw_top;
        int rd;
        rst_n = 1'b0; w_en = 0; overflow_clr = 0; rd_ptr = 0;
        repeat (3) @(posedge wclk);
        #2 rst_n = 1'b1;
        chk("reset_b_wptr", 32'(b_wptr), 0);
        chk("reset_full",   32'(full),   0);

        // Fill: eight writes against read pointer 0.
        for (int i = 1; i <= 8; i++) begin
            tick(1, 0, 0);
            chk("fill_b_wptr", 32'(b_wptr), 32'(i));
            if (i == 1) chk("first_g_wptr", 32'(g_wptr), 32'b0001);
            if (i == 5) chk("af_before6", 32'(almost_full), 0);
            if (i == 6) chk("af_at6", 32'(almost_full), 1);
        end
        chk("fill_b_wptr8", 32'(b_wptr), 32'b1000);
        chk("fill_g_wptr8", 32'(g_wptr), 32'b1100);
        chk("fill_wlevel8", 32'(wlevel), 8);
        chk("fill_full",    32'(full),   1);
        w_en = 1; #1;
        chk("full_blocks_fire", 32'(w_fire), 0);

        // Overflow behaviour.
        tick(1, 0, 0);
        chk("ovf_b_wptr_hold", 32'(b_wptr), 8);
        chk("ovf_set", 32'(overflow), 1);
        tick(1, 0, 1);
        chk("ovf_set_beats_clr", 32'(overflow), 1);
        tick(0, 0, 1);
        chk("ovf_clr", 32'(overflow), 0);

        // Drain: read pointer jumps to binary 3.
        tick(0, 3, 0);
        chk("drain_full",   32'(full),        0);
        chk("drain_wlevel", 32'(wlevel),      5);
        chk("drain_af",     32'(almost_full), 0);

        // Simultaneous write and read advance keeps level at 5.
        tick(1, 4, 0);
        chk("simul_wlevel", 32'(wlevel),      5);
        chk("simul_af",     32'(almost_full), 0);
        chk("simul_b_wptr", 32'(b_wptr),      9);

        // Wrap-around with the reader two entries behind.
        tick(0, 7, 0);
        chk("wrap_pre_level", 32'(wlevel), 2);
        saw_top = 0;
        for (int i = 0; i < 20; i++) begin
            int nw;
            nw = (10 + i) % 16;
            tick(1, (nw + 14) % 16, 0);
            chk("wrap_b_wptr", 32'(b_wptr), 32'(nw));
            chk("wrap_level",  32'(wlevel), 2);
            chk("wrap_full",   32'(full),   0);
            if (nw == 15) begin
                chk("wrap_g_top", 32'(g_wptr), 32'b1000);
                saw_top = 1;
            end
            if (nw == 0 && saw_top) chk("wrap_g_zero", 32'(g_wptr), 32'b0000);
        end

        // Randomised traffic with varying write/read pressure; reader never passes writer.
        rd = int'(rd_ptr);
        for (int i = 0; i < 3000; i++) begin
            int wp, rp, lag;
            wp  = 20 + 30 * ((i / 250) % 3);
            rp  = 80 - 30 * ((i / 250) % 3);
            lag = (m_w - rd + 16) % 16;
            if (m_full) lag = DEPTH;
            if (lag > 0 && $urandom_range(0, 99) < rp) rd = (rd + 1) % 16;
            tick($urandom_range(0, 99) < wp, rd, ($urandom % 16) == 0);
        end

        // Mid-stream asynchronous reset.
        w_en = 1;
        #3 rst_n = 1'b0;
        rd_ptr = 0;
        #1;
        chk("arst_b_wptr",   32'(b_wptr),      0);
        chk("arst_g_wptr",   32'(g_wptr),      0);
        chk("arst_full",     32'(full),        0);
        chk("arst_af",       32'(almost_full), 0);
        chk("arst_wlevel",   32'(wlevel),      0);
        chk("arst_overflow", 32'(overflow),    0);
        @(posedge wclk);
        #2 rst_n = 1'b1;
        tick(1, 0, 0);
        chk("post_rst_b_wptr", 32'(b_wptr), 1);
        chk("post_rst_g_wptr", 32'(g_wptr), 32'b0001);
        tick(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_handler.md
# wptr_handler

Write-side pointer and status controller for the asynchronous FIFO, running entirely in the write clock domain. It counts accepted writes and keeps binary and Gray copies of the write pointer. It compares the write pointer against the read pointer, which arrives already synchronised into this domain, to produce registered full, almost-full, fill-level and sticky overflow indications. It is the write-end counterpart of the read pointer handler. Its Gray pointer feeds the write-to-read synchroniser, and its binary pointer addresses the FIFO memory.

## Interface
Parameters:
- PTR_WIDTH, 3, memory address width; FIFO depth = 2^PTR_WIDTH; must be >= 2.
- AF_THRESH, 6, almost-full threshold in entries; legal range 1..2^PTR_WIDTH.

Ports:
- wclk  input  1  write clock; single clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- w_en  input  1  write request.
- g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised to wclk.
- overflow_clr  input  1  clears the sticky overflow flag.
- w_fire  output  1  combinational, w_en & !full; write strobe for the memory.
- b_wptr  output  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits are the memory address.
- g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered.
- full  output  1  registered full flag.
- almost_full  output  1  registered, set when level >= AF_THRESH.
- wlevel  output  PTR_WIDTH+1  registered fill level, 0..2^PTR_WIDTH.
- overflow  output  1  sticky flag: a write was attempted while full.

## Operation
- Next binary pointer: b_wptr_next = b_wptr + w_fire. Arithmetic is modulo 2^(PTR_WIDTH+1), so 2^(PTR_WIDTH+1)-1 wraps to 0.
- g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1).
- Full condition: g_wptr_next equals g_rptr_sync with its two MSBs inverted and the remaining bits unchanged.
- Read pointer in binary: b_rptr_sync = gray2bin(g_rptr_sync). Bit i is the XOR of Gray bits PTR_WIDTH down to i.
- level_next = (b_wptr_next - b_rptr_sync) mod 2^(PTR_WIDTH+1), width PTR_WIDTH+1.
- almost_full_next = (level_next >= AF_THRESH).
- Overflow set condition is w_en & full. Set has priority over overflow_clr in the same cycle. Otherwise overflow_clr clears the flag.
- Writes while full are dropped: the pointers do not move and w_fire = 0.
- The status flags are conservative. Synchroniser latency means g_rptr_sync lags the true read pointer. As a result, full and level may overstate occupancy, but they never understate it.
- Reset value of every registered output is 0: b_wptr, g_wptr, full, almost_full, wlevel, overflow. w_fire follows w_en after reset because full is 0.
- Reset asserted mid-operation clears all state immediately and asynchronously. The first write after reset release targets address 0.

## Timing
- All state updates on the rising edge of wclk.
- b_wptr, g_wptr, full, almost_full and wlevel update on the same edge that accepts a write. The new values are visible in the following cycle.
- full is registered, so the cycle after the accepting edge of the filling write already shows full = 1 and blocks further writes. No overshoot is possible.
- A change on g_rptr_sync is reflected in full, almost_full and wlevel one wclk edge later, even when w_en = 0.
- A write accepted in the same cycle that g_rptr_sync changes uses both new values in level_next.
- overflow rises one edge after the offending w_en & full cycle.

## Structure
- Shared package afifo_pkg holds:
  - the default PTR_WIDTH;
  - a bin2gray function;
  - a gray2bin function.
- The read-side handler uses the same package.
- One sub-module is natural: gray2bin, a parameterised combinational converter for g_rptr_sync. It is reusable on the read side to compute the read level.
- Reset polarity and port names match the read-side handler, with wclk replacing rclk.

## Test plan
All scenarios use PTR_WIDTH=3 and AF_THRESH=6.
- **Reset:** assert rst_n=0 mid-stream with w_en=1 -> all registered outputs are 0 immediately; after release, first write gives b_wptr=1, g_wptr=4'b0001.
- **Fill:** g_rptr_sync=0, w_en=1 for 8 cycles -> almost_full=1 after the 6th accepted write. After the 8th: b_wptr=4'b1000, g_wptr=4'b1100, wlevel=8, full=1; w_fire=0 from then on.
- **Overflow:** while full, w_en=1 for 1 cycle -> b_wptr stays 8 and overflow=1 persists. overflow_clr=1 concurrent with w_en&full -> overflow stays 1. overflow_clr alone -> overflow=0.
- **Drain:** while full, set g_rptr_sync=4'b0010 (binary 3) -> next cycle full=0, wlevel=5, almost_full=0.
- **Wrap-around:** 20 writes with g_rptr_sync tracking 2 entries behind -> b_wptr wraps 15->0 (g_wptr 4'b1000->4'b0000). full never asserts and wlevel stays at 2.
- **Simultaneous:** wlevel=5 with w_en=1 and g_rptr_sync advancing by 1 in the same cycle -> wlevel=5 next cycle and almost_full stays 0.
